// File: rtl/scmp_bus_pak.sv
// scmp_bus_pak: shared state encoding, status flag bit positions and counter widths for the SC/MP bus arbiter.
package scmp_bus_pak;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_STRB, S_DONE} state_t;
  localparam int FLAG_R = 0;
  localparam int FLAG_I = 1;
  localparam int FLAG_D = 2;
  localparam int FLAG_H = 3;
  localparam int STB_W  = 4;
  localparam int WAIT_W = 8;
  function automatic logic [7:0] addr_phase_data(input logic [3:0] flags, input logic [3:0] page);
    return {flags[FLAG_H], flags[FLAG_D], flags[FLAG_I], flags[FLAG_R], page};
  endfunction
endpackage

// File: rtl/scmp_bus_timer.sv
// scmp_bus_timer: loadable saturating up/down counter shared by the strobe-width and wait-timeout counts.
module scmp_bus_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = load ? load_val
          : !en  ? cnt_q
          : up   ? (&cnt_q ? cnt_q : cnt_q + 1'b1)
          :        (|cnt_q ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/scmp_bus_arb.sv
// scmp_bus_arb: SC/MP-style daisy-chained bus master sequencing IDLE/REQ/ADDR/STRB/DONE bus cycles.
// Optional NHOLD wait timeout with err_o is enabled by defining SCMP_BUS_TIMEOUT_EN.
module scmp_bus_arb
  import scmp_bus_pak::*;
#(
  parameter int unsigned STROBE_MIN = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        req_wr_i,
  input  logic [15:0] req_addr_i,
  input  logic [3:0]  req_flags_i,
  input  logic [7:0]  req_wdata_i,
  output logic        ack_o,
  output logic [7:0]  rdata_o,
  output logic        breq_o,
  input  logic        enin_i,
  output logic        enout_o,
  output logic [11:0] addr_o,
  input  logic [7:0]  d_i,
  output logic [7:0]  d_o,
  output logic        d_oe_o,
  output logic        ads_n_o,
  output logic        rd_n_o,
  output logic        wr_n_o,
  input  logic        nhold_i
`ifdef SCMP_BUS_TIMEOUT_EN
  ,
  output logic        err_o
`endif
);
  if (STROBE_MIN < 1 || STROBE_MIN > 15) begin : g_bad_strobe_min
    $error("scmp_bus_arb: STROBE_MIN must be 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("scmp_bus_arb: TIMEOUT must be 1..255");
  end

  state_t      state_q, state_d;
  logic        breq_q, breq_d, ads_n_q, ads_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic        ack_q, ack_d, doe_q, doe_d, wr_q, wr_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d, rdata_q, rdata_d, wdata_q, wdata_d;
  logic [STB_W-1:0] stb_cnt;
  logic        grant, stb_min_met, stb_ok, to_hit;

  scmp_bus_timer #(.W(STB_W)) u_stb (
    .clk(clk), .rst(rst), .load(state_q == S_ADDR), .en(state_q == S_STRB), .up(1'b1),
    .load_val(STB_W'(1)), .cnt_o(stb_cnt)
  );

  assign stb_min_met = stb_cnt >= STB_W'(STROBE_MIN);
  assign stb_ok      = stb_min_met && nhold_i;

`ifdef SCMP_BUS_TIMEOUT_EN
  logic [WAIT_W-1:0] wt_cnt;
  logic              err_q, err_d;
  scmp_bus_timer #(.W(WAIT_W)) u_wait (
    .clk(clk), .rst(rst), .load(state_q == S_ADDR),
    .en(state_q == S_STRB && stb_min_met && !nhold_i), .up(1'b1),
    .load_val('0), .cnt_o(wt_cnt)
  );
  // a normal completion on the same edge wins over the timeout
  assign to_hit = wt_cnt >= WAIT_W'(TIMEOUT) && !stb_ok;
  assign err_d  = state_q == S_STRB && to_hit;
  assign err_o  = err_q;
`else
  assign to_hit = 1'b0;
`endif

  assign grant = enin_i && (state_q == S_REQ || (state_q == S_DONE && req_i));

  always_comb begin
    state_d = state_q;
    breq_d  = breq_q;
    ads_n_d = 1'b1;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    ack_d   = 1'b0;
    doe_d   = doe_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: if (req_i) begin
        state_d = S_REQ;
        breq_d  = 1'b1;
      end
      S_ADDR: begin
        state_d = S_STRB;
        rd_n_d  = wr_q;
        wr_n_d  = !wr_q;
        doe_d   = wr_q;
        dout_d  = wr_q ? wdata_q : dout_q;
      end
      S_STRB: if (stb_ok || to_hit) begin
        state_d = S_DONE;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        ack_d   = 1'b1;
        rdata_d = wr_q ? rdata_q : to_hit ? 8'hFF : d_i;
      end
      S_DONE: begin
        state_d = S_IDLE;
        breq_d  = 1'b0;
        doe_d   = 1'b0;
      end
      default: ;
    endcase
    if (grant) begin
      state_d = S_ADDR;
      breq_d  = 1'b1;
      ads_n_d = 1'b0;
      doe_d   = 1'b1;
      addr_d  = req_addr_i[11:0];
      dout_d  = addr_phase_data(req_flags_i, req_addr_i[15:12]);
      wr_d    = req_wr_i;
      wdata_d = req_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      breq_q  <= 1'b0;
      ads_n_q <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      doe_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
`ifdef SCMP_BUS_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      breq_q  <= breq_d;
      ads_n_q <= ads_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      ack_q   <= ack_d;
      doe_q   <= doe_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
`ifdef SCMP_BUS_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end

  assign enout_o = enin_i && state_q == S_IDLE;
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign breq_o  = breq_q;
  assign addr_o  = addr_q;
  assign d_o     = dout_q;
  assign d_oe_o  = doe_q;
  assign ads_n_o = ads_n_q;
  assign rd_n_o  = rd_n_q;
  assign wr_n_o  = wr_n_q;
endmodule

// File: tb/tb_scmp_bus_arb.sv
// tb_scmp_bus_arb: randomized transaction-level check of scmp_bus_arb against a cycle-count model of the bus protocol.
module tb_scmp_bus_arb;
  localparam int SM  = 2;
  localparam int TMO = 4;

  logic        clk = 0, rst = 1;
  logic        req_i = 0, req_wr_i = 0, enin_i = 0, nhold_i = 1;
  logic [15:0] req_addr_i = 0;
  logic [3:0]  req_flags_i = 0;
  logic [7:0]  req_wdata_i = 0, d_i = 0;
  logic        ack_o, breq_o, enout_o, d_oe_o, ads_n_o, rd_n_o, wr_n_o;
  logic [7:0]  rdata_o, d_o;
  logic [11:0] addr_o;
`ifdef SCMP_BUS_TIMEOUT_EN
  logic        err_o;
`endif

  int checks = 0, failures = 0;
  logic [7:0] last_rd = 0;

  scmp_bus_arb #(.STROBE_MIN(SM), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i),
    .req_flags_i(req_flags_i), .req_wdata_i(req_wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .breq_o(breq_o), .enin_i(enin_i), .enout_o(enout_o), .addr_o(addr_o), .d_i(d_i),
    .d_o(d_o), .d_oe_o(d_oe_o), .ads_n_o(ads_n_o), .rd_n_o(rd_n_o), .wr_n_o(wr_n_o),
    .nhold_i(nhold_i)
`ifdef SCMP_BUS_TIMEOUT_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bus transaction; starts and ends on a falling edge. Expected timing:
  // grant edge E, ADDR visible after E, strobe low SM+waits cycles, ack right after.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [3:0] fl,
                         input logic [7:0] wd, input logic [7:0] rd, input int gdly, input int w,
                         input bit b2b_in, input bit next_b2b);
    int n = 0, k = 0, ads_cnt = 0, ads_at = -1, rd_cnt = 0, wr_cnt = 0, bad = 0, ack_at = -1;
    int e, ew;
    bit tmo = 0;
    logic [11:0] a_ads = 0;
    logic [7:0]  d_ads = 0;
    logic        oe_ads = 0;
    e  = b2b_in ? 1 : (gdly + 1 > 2 ? gdly + 1 : 2);
    ew = w;
`ifdef SCMP_BUS_TIMEOUT_EN
    if (w > TMO) begin ew = TMO; tmo = 1; end
    else if (w == TMO) ew = TMO;
`endif
    req_wr_i = wr; req_addr_i = addr; req_flags_i = fl; req_wdata_i = wd; d_i = rd;
    req_i = 1; enin_i = (gdly == 0); nhold_i = 1;
    while (ack_at < 0 && n < 80) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!ads_n_o) begin ads_cnt++; ads_at = n; a_ads = addr_o; d_ads = d_o; oe_ads = d_oe_o; end
      if (!rd_n_o) rd_cnt++;
      if (!wr_n_o) wr_cnt++;
      if (!rd_n_o && !wr_n_o) bad++;
      if (!breq_o || enout_o) bad++;
      if ((!rd_n_o || !wr_n_o) && d_oe_o !== wr) bad++;
      if (!wr_n_o && d_o !== wd) bad++;
      if (ack_o) ack_at = n;
      if (!rd_n_o || !wr_n_o) k++;
      nhold_i = !((!rd_n_o || !wr_n_o) && k >= SM && k < SM + w);
      enin_i  = (n >= gdly);
    end
    nhold_i = 1;
    check("ack_cycle", ack_at, e + 1 + SM + ew);
    check("ads_cycle", ads_at, e);
    check("ads_once", ads_cnt, 1);
    check("addr_ads", a_ads, addr[11:0]);
    check("d_ads", d_ads, {fl, addr[15:12]});
    check("oe_ads", oe_ads, 1);
    check("rd_low", rd_cnt, wr ? 0 : SM + ew);
    check("wr_low", wr_cnt, wr ? SM + ew : 0);
    check("protocol", bad, 0);
    if (!wr) last_rd = tmo ? 8'hFF : rd;
    check("rdata", rdata_o, last_rd);
    check("oe_done", d_oe_o, wr);
    if (wr) check("d_done", d_o, wd);
`ifdef SCMP_BUS_TIMEOUT_EN
    check("err", err_o, tmo);
`endif
    if (!next_b2b) begin
      req_i = 0; enin_i = 1;
      @(negedge clk);
      check("idle_breq", breq_o, 0);
      check("idle_enout", enout_o, 1);
      check("idle_ack", ack_o, 0);
    end
  endtask

  initial begin
    bit b2b = 0, nb;
    int t = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ads", ads_n_o, 1);
    check("rst_rd", rd_n_o, 1);
    check("rst_wr", wr_n_o, 1);
    check("rst_breq", breq_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_oe", d_oe_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_d", d_o, 0);
    check("rst_rdata", rdata_o, 0);
    rst = 0;
    @(negedge clk);
    run_txn(0, 16'h3A5C, 4'b0010, 8'h00, 8'h7E, 0, 0, 0, 0);
    run_txn(1, 16'h0123, 4'b0000, 8'hC3, 8'h00, 0, 3, 0, 0);
    run_txn(0, 16'h1456, 4'b1001, 8'h00, 8'h5A, 10, 0, 0, 0);
    run_txn(0, 16'h2111, 4'b0101, 8'h00, 8'h31, 0, 0, 0, 1);
    run_txn(0, 16'h4222, 4'b1110, 8'h00, 8'h42, 0, 1, 1, 0);
`ifdef SCMP_BUS_TIMEOUT_EN
    run_txn(0, 16'h0F00, 4'b0000, 8'h00, 8'h11, 0, 30, 0, 0);
`endif
    for (int i = 0; i < 40; i++) begin
      nb = (i < 39) && ($urandom_range(0, 2) == 0);
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
              b2b ? 0 : int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), b2b, nb);
      b2b = nb;
    end
    req_wr_i = 1; req_addr_i = 16'h0777; req_wdata_i = 8'h99; req_i = 1; enin_i = 1; nhold_i = 1;
    while (wr_n_o && t < 20) begin @(negedge clk); t++; end
    check("rst_reach_strb", wr_n_o, 0);
    #2 rst = 1;
    #1;
    check("arst_wr", wr_n_o, 1);
    check("arst_oe", d_oe_o, 0);
    check("arst_breq", breq_o, 0);
    check("arst_ack", ack_o, 0);
    check("arst_ads", ads_n_o, 1);
    req_i = 0;
    @(posedge clk); #1;
    check("arst_hold_ack", ack_o, 0);
    check("arst_hold_wr", wr_n_o, 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("post_rst_enout", enout_o, 1);
    check("post_rst_rdata", rdata_o, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
